// File: rtl/bf_exec_core_if.sv
`default_nettype none
// ==================================================================
// bf_exec_core_if : valid/ready byte streams between host and core
// Rev 1.0
// ==================================================================
interface bf_exec_core_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/bf_exec_core.sv
`default_nettype none
// ==================================================================
// bf_exec_core : Brainfuck execution core with bracket stack, byte
// streams, data clear, program-load port and error reporting. Rev 1.0
// ==================================================================
module bf_exec_core #(
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int DATA_ADDR_WIDTH = 10,
  parameter int CELL_WIDTH      = 8,
  parameter int STACK_DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       prog_we,
  input  logic [PROG_ADDR_WIDTH-1:0] prog_waddr,
  input  logic [7:0]                 prog_wdata,
  input  logic                       start,
  input  logic                       abort,
  bf_exec_core_if.slave              io,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 error,
  output logic [31:0]                step_count
);
  localparam int PAW = PROG_ADDR_WIDTH;
  localparam int DAW = DATA_ADDR_WIDTH;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PAW-1:0] IPTR_LAST = '1;
  localparam logic [DAW-1:0] DPTR_LAST = '1;
  localparam logic [SPW-1:0] SP_FULL   = SPW'(STACK_DEPTH);
  localparam logic [PAW:0]   DEPTH_ONE = (PAW+1)'(1);
  localparam logic [7:0] OP_RIGHT = 8'h3E, OP_LEFT = 8'h3C, OP_INC   = 8'h2B,
                         OP_DEC   = 8'h2D, OP_OUT  = 8'h2E, OP_IN    = 8'h2C,
                         OP_OPEN  = 8'h5B, OP_CLOSE = 8'h5D, OP_HALT = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_DECODE, S_EXEC,
    S_OUT_WAIT, S_IN_WAIT, S_SCAN_RD, S_SCAN_CHK
  } state_t;

  state_t                state_q, state_d;
  logic [PAW-1:0]        iptr_q, iptr_d;
  logic [DAW-1:0]        dptr_q, dptr_d;
  logic [DAW-1:0]        clr_q, clr_d;
  logic [PAW:0]          depth_q, depth_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic [PAW-1:0]        stack_q [STACK_DEPTH];
  logic [PAW-1:0]        stack_d [STACK_DEPTH];
  logic                  done_q, done_d;
  logic [1:0]            error_q, error_d;
  logic [31:0]           steps_q, steps_d;
  logic [7:0]            out_data_q, out_data_d;

  logic [7:0]            prog_mem [2**PAW];
  logic [CELL_WIDTH-1:0] data_mem [2**DAW];
  logic [PAW-1:0]        prog_addr;
  logic                  prog_wr, prog_rd;
  logic [7:0]            prog_rdata;
  logic [DAW-1:0]        data_addr;
  logic                  data_wr, data_rd;
  logic [CELL_WIDTH-1:0] data_wdata, data_rdata;
  logic                  count, advance, halt;
  logic [SIW-1:0]        sp_idx, top_idx;

  assign sp_idx  = SIW'(sp_q);
  assign top_idx = SIW'(sp_q - 1'b1);

  // Single-port memories; read data holds until the next read strobe,
  // so the opcode and cell fetched in FETCH stay valid through EXEC.
  always_ff @(posedge clk) begin
    if (prog_wr)
      prog_mem[prog_addr] <= prog_wdata;
    else if (prog_rd)
      prog_rdata <= prog_mem[prog_addr];
  end

  always_ff @(posedge clk) begin
    if (data_wr)
      data_mem[data_addr] <= data_wdata;
    else if (data_rd)
      data_rdata <= data_mem[data_addr];
  end

  always_comb begin
    state_d    = state_q;
    iptr_d     = iptr_q;
    dptr_d     = dptr_q;
    clr_d      = clr_q;
    depth_d    = depth_q;
    sp_d       = sp_q;
    stack_d    = stack_q;
    done_d     = done_q;
    error_d    = error_q;
    steps_d    = steps_q;
    out_data_d = out_data_q;
    prog_addr  = iptr_q;
    prog_wr    = 1'b0;
    prog_rd    = 1'b0;
    data_addr  = dptr_q;
    data_wr    = 1'b0;
    data_rd    = 1'b0;
    data_wdata = '0;
    count      = 1'b0;
    advance    = 1'b0;
    halt       = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (prog_we) begin
            prog_addr = prog_waddr;
            prog_wr   = 1'b1;
          end
          if (start) begin
            done_d  = 1'b0;
            error_d = 2'd0;
            steps_d = '0;
            clr_d   = '0;
            sp_d    = '0;
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: begin
          data_addr = clr_q;
          data_wr   = 1'b1;
          clr_d     = clr_q + 1'b1;
          if (clr_q == DPTR_LAST) begin
            iptr_d  = '0;
            dptr_d  = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          prog_rd = 1'b1;
          data_rd = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          case (prog_rdata)
            OP_RIGHT: begin dptr_d = dptr_q + 1'b1; count = 1'b1; advance = 1'b1; end
            OP_LEFT:  begin dptr_d = dptr_q - 1'b1; count = 1'b1; advance = 1'b1; end
            OP_INC: begin
              data_wr    = 1'b1;
              data_wdata = data_rdata + 1'b1;
              count      = 1'b1;
              advance    = 1'b1;
            end
            OP_DEC: begin
              data_wr    = 1'b1;
              data_wdata = data_rdata - 1'b1;
              count      = 1'b1;
              advance    = 1'b1;
            end
            OP_OUT: begin
              out_data_d = 8'(data_rdata);
              state_d    = S_OUT_WAIT;
            end
            OP_IN: state_d = S_IN_WAIT;
            OP_OPEN: begin
              if (data_rdata == '0) begin
                // The '[' itself retires; the skipped body and its ']' do not.
                count   = 1'b1;
                depth_d = DEPTH_ONE;
                state_d = S_SCAN_RD;
              end else if (sp_q == SP_FULL) begin
                error_d = 2'd1;
                state_d = S_IDLE;
              end else begin
                stack_d[sp_idx] = iptr_q;
                sp_d    = sp_q + 1'b1;
                count   = 1'b1;
                advance = 1'b1;
              end
            end
            OP_CLOSE: begin
              if (sp_q == '0) begin
                error_d = 2'd2;
                state_d = S_IDLE;
              end else if (data_rdata != '0) begin
                iptr_d  = stack_q[top_idx] + 1'b1;
                count   = 1'b1;
                state_d = S_FETCH;
              end else begin
                sp_d    = sp_q - 1'b1;
                count   = 1'b1;
                advance = 1'b1;
              end
            end
            OP_HALT: halt = 1'b1;
            default: begin count = 1'b1; advance = 1'b1; end
          endcase
        end
        S_OUT_WAIT: begin
          if (io.out_ready) begin
            count   = 1'b1;
            advance = 1'b1;
          end
        end
        S_IN_WAIT: begin
          if (io.in_valid) begin
            data_wr    = 1'b1;
            data_wdata = CELL_WIDTH'(io.in_data);
            count      = 1'b1;
            advance    = 1'b1;
          end
        end
        S_SCAN_RD: begin
          if (iptr_q == IPTR_LAST) begin
            error_d = 2'd3;
            state_d = S_IDLE;
          end else begin
            prog_addr = iptr_q + 1'b1;
            prog_rd   = 1'b1;
            iptr_d    = iptr_q + 1'b1;
            state_d   = S_SCAN_CHK;
          end
        end
        S_SCAN_CHK: begin
          state_d = S_SCAN_RD;
          case (prog_rdata)
            OP_HALT: begin
              error_d = 2'd3;
              state_d = S_IDLE;
            end
            OP_OPEN: depth_d = depth_q + 1'b1;
            OP_CLOSE: begin
              if (depth_q == DEPTH_ONE)
                advance = 1'b1;
              else
                depth_d = depth_q - 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (count)
      steps_d = (steps_q == '1) ? steps_q : steps_q + 32'd1;
    if (advance) begin
      if (iptr_q == IPTR_LAST)
        halt = 1'b1;
      else begin
        iptr_d  = iptr_q + 1'b1;
        state_d = S_FETCH;
      end
    end
    // A halt with open brackets still on the stack reports an unmatched '['.
    if (halt) begin
      state_d = S_IDLE;
      if (sp_d != '0)
        error_d = 2'd3;
      else
        done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      iptr_q     <= '0;
      dptr_q     <= '0;
      clr_q      <= '0;
      depth_q    <= '0;
      sp_q       <= '0;
      done_q     <= 1'b0;
      error_q    <= 2'd0;
      steps_q    <= '0;
      out_data_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++)
        stack_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      iptr_q     <= iptr_d;
      dptr_q     <= dptr_d;
      clr_q      <= clr_d;
      depth_q    <= depth_d;
      sp_q       <= sp_d;
      done_q     <= done_d;
      error_q    <= error_d;
      steps_q    <= steps_d;
      out_data_q <= out_data_d;
      stack_q    <= stack_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign step_count   = steps_q;
  assign io.in_ready  = (state_q == S_IN_WAIT);
  assign io.out_valid = (state_q == S_OUT_WAIT);
  assign io.out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_bf_exec_core.sv
`default_nettype none
// tb_bf_exec_core: directed programs checked against a reference
// Brainfuck interpreter plus hand-computed literal results.
module tb_bf_exec_core;
  localparam int PAW   = 6;
  localparam int DAW   = 4;
  localparam int SD    = 4;
  localparam int NCELL = 1 << DAW;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           prog_we = 1'b0;
  logic [PAW-1:0] prog_waddr = '0;
  logic [7:0]     prog_wdata = '0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           busy, done;
  logic [1:0]     error;
  logic [31:0]    step_count;

  always #5 clk = ~clk;

  bf_exec_core_if io();

  bf_exec_core #(
    .PROG_ADDR_WIDTH(PAW),
    .DATA_ADDR_WIDTH(DAW),
    .CELL_WIDTH(8),
    .STACK_DEPTH(SD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .prog_we(prog_we),
    .prog_waddr(prog_waddr),
    .prog_wdata(prog_wdata),
    .start(start),
    .abort(abort),
    .io(io),
    .busy(busy),
    .done(done),
    .error(error),
    .step_count(step_count)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_out[$];
  int         exp_steps, exp_err, exp_done;
  bit         model_on = 1'b0;
  int         first_ov;
  logic [7:0] last_out;
  int         saved_steps;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference interpreter: plain instruction-level semantics, no cycle timing.
  task automatic model_run(input string p, input logic [7:0] inb);
    logic [7:0] mem [NCELL];
    int         stk[$];
    int         ip, dp, depth, j;
    bit         stop;
    logic [7:0] c;
    ip = 0; dp = 0; stop = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    exp_out.delete();
    exp_steps = 0; exp_err = 0; exp_done = 0;
    for (int guard = 0; guard < 10000 && !stop; guard++) begin
      c = (ip < p.len()) ? p[ip] : 8'h00;
      case (c)
        8'h00: begin
          if (stk.size() != 0) exp_err = 3; else exp_done = 1;
          stop = 1'b1;
        end
        ">": begin dp = (dp + 1) % NCELL; exp_steps++; ip++; end
        "<": begin dp = (dp + NCELL - 1) % NCELL; exp_steps++; ip++; end
        "+": begin mem[dp] = mem[dp] + 8'd1; exp_steps++; ip++; end
        "-": begin mem[dp] = mem[dp] - 8'd1; exp_steps++; ip++; end
        ".": begin exp_out.push_back(mem[dp]); exp_steps++; ip++; end
        ",": begin mem[dp] = inb; exp_steps++; ip++; end
        "[": begin
          if (mem[dp] != 8'h00) begin
            if (stk.size() == SD) begin
              exp_err = 1; stop = 1'b1;
            end else begin
              stk.push_back(ip); exp_steps++; ip++;
            end
          end else begin
            exp_steps++;
            depth = 1; j = ip;
            while (depth != 0 && !stop) begin
              j++;
              c = (j < p.len()) ? p[j] : 8'h00;
              if (c == 8'h00) begin exp_err = 3; stop = 1'b1; end
              else if (c == "[") depth++;
              else if (c == "]") depth--;
            end
            ip = j + 1;
          end
        end
        "]": begin
          if (stk.size() == 0) begin
            exp_err = 2; stop = 1'b1;
          end else begin
            exp_steps++;
            if (mem[dp] != 8'h00) ip = stk[$] + 1;
            else begin void'(stk.pop_back()); ip++; end
          end
        end
        default: begin exp_steps++; ip++; end
      endcase
    end
  endtask

  task automatic load(input string p);
    for (int i = 0; i <= p.len(); i++) begin
      prog_we    = 1'b1;
      prog_waddr = PAW'(i);
      prog_wdata = (i < p.len()) ? p[i] : 8'h00;
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic run(input string p, input bit do_load, input logic [7:0] inb,
                     input int in_delay, input int out_delay);
    int cyc, ow, iw;
    if (do_load) load(p);
    model_run(p, inb);
    last_out = 8'hAA;
    first_ov = -1;
    model_on = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; ow = 0; iw = 0;
    while (busy && cyc < 3000) begin
      if (io.out_valid && first_ov < 0) first_ov = cyc;
      ow = io.out_valid ? ow + 1 : 0;
      iw = io.in_ready ? iw + 1 : 0;
      io.out_ready = io.out_valid && (ow > out_delay);
      io.in_valid  = io.in_ready && (iw > in_delay);
      io.in_data   = io.in_valid ? inb : 8'h00;
      @(posedge clk); #1;
      cyc++;
    end
    io.out_ready = 1'b0;
    io.in_valid  = 1'b0;
    model_on     = 1'b0;
    check({p, " timeout"}, 32'(busy), 32'd0);
    check({p, " steps"}, step_count, 32'(exp_steps));
    check({p, " error"}, 32'(error), 32'(exp_err));
    check({p, " done"}, 32'(done), 32'(exp_done));
    check({p, " outputs_left"}, 32'(exp_out.size()), 32'd0);
  endtask

  // Cycle compare: output transfers against the model, handshake holding.
  logic       p_ov = 1'b0, p_or = 1'b0, p_ir = 1'b0, p_iv = 1'b0;
  logic [7:0] p_od = 8'h00;
  always @(negedge clk) begin
    if (model_on) begin
      if (p_ov && !p_or)
        check("out_stable", 32'({io.out_valid, io.out_data}), 32'({1'b1, p_od}));
      if (p_ir && !p_iv)
        check("in_ready_hold", 32'(io.in_ready), 32'd1);
      if (io.out_valid && io.out_ready) begin
        last_out = io.out_data;
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra got %0h expected no byte", io.out_data);
        end else begin
          check("out_data", 32'(io.out_data), 32'(exp_out.pop_front()));
        end
      end
    end
    p_ov = io.out_valid;
    p_or = io.out_ready;
    p_od = io.out_data;
    p_ir = io.in_ready;
    p_iv = io.in_valid;
  end

  initial begin
    io.in_valid  = 1'b0;
    io.in_data   = 8'h00;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst steps", step_count, 32'd0);
    check("rst io", 32'({io.in_ready, io.out_valid, io.out_data}), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run("+++++.", 1'b1, 8'h00, 0, 0);
    check("lit1 out", 32'(last_out), 32'h05);
    check("lit1 steps", step_count, 32'd6);
    check("lit1 done", 32'(done), 32'd1);

    run("++[>+++<-]>.", 1'b1, 8'h00, 0, 0);
    check("lit2 out", 32'(last_out), 32'h06);
    check("lit2 steps", step_count, 32'd19);

    run("[+++].", 1'b1, 8'h00, 0, 0);
    check("lit3 out", 32'(last_out), 32'h00);
    check("lit3 steps", step_count, 32'd2);

    run("+[", 1'b1, 8'h00, 0, 0);
    check("lit4 err", 32'(error), 32'd3);
    run("[+", 1'b1, 8'h00, 0, 0);
    check("lit5 err", 32'(error), 32'd3);
    run("]", 1'b1, 8'h00, 0, 0);
    check("lit6 err", 32'({done, error}), 32'd2);
    run("+[+[+[+[+[", 1'b1, 8'h00, 0, 0);
    check("lit7 err", 32'(error), 32'd1);

    run(",+.", 1'b1, 8'h41, 10, 5);
    check("lit8 out", 32'(last_out), 32'h42);
    run("<-.", 1'b1, 8'h00, 0, 0);
    check("lit9 out", 32'(last_out), 32'hFF);
    run(".", 1'b1, 8'h00, 0, 0);
    check("start_to_out", 32'(first_ov), 32'(NCELL + 3));

    // Abort an endless loop, then start+abort together must be ignored.
    load("+[]");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort pre busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort idle", 32'({busy, io.out_valid, io.in_ready}), 32'd0);
    check("abort flags", 32'({done, error}), 32'd0);
    saved_steps = int'(step_count);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", 32'(busy), 32'd0);
    check("start+abort steps", step_count, 32'(saved_steps));

    // Mid-run reset with a dropped program write, then re-run the kept program.
    load("++[>+++<-]>.");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    prog_we    = 1'b1;
    prog_waddr = '0;
    prog_wdata = "]";
    @(posedge clk); #1;
    prog_we = 1'b0;
    resetn  = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst steps", step_count, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run("++[>+++<-]>.", 1'b0, 8'h00, 0, 0);
    check("rerun out", 32'(last_out), 32'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
